// File: rtl/snax_gemm_pkg.sv
// Shared types and constants for the SNAX GEMM output path: writer FSM states,
// default TCDM request/response structs and the tile beat-count helper.
package snax_gemm_pkg;

  localparam int unsigned DataWidth = 64;
  localparam int unsigned TcdmPorts = 16;
  localparam int unsigned CWidth    = 2048;
  localparam int unsigned AddrWidth = 17;

  typedef enum logic {
    IDLE,
    WRITE
  } state_e;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2
  } amo_op_e;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   write;
    amo_op_e                amo;
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic [0:0]             user;
  } tcdm_req_chan_t;

  typedef struct packed {
    logic           q_valid;
    tcdm_req_chan_t q;
  } tcdm_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    logic           p_valid;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_t;

  // A tile is written as whole beats, one word per port per beat.
  function automatic int unsigned beat_count(input int unsigned c_width,
                                             input int unsigned ports,
                                             input int unsigned data_width);
    return c_width / (ports * data_width);
  endfunction

endpackage

// File: rtl/snax_gemm_c_writer.sv
// Captures one C result tile and writes it to TCDM as full-width beats,
// each port handshaking independently; pulses done_o after the last beat.
module snax_gemm_c_writer
  import snax_gemm_pkg::*;
#(
  parameter int unsigned DataWidth = snax_gemm_pkg::DataWidth,
  parameter int unsigned TcdmPorts = snax_gemm_pkg::TcdmPorts,
  parameter int unsigned CWidth    = snax_gemm_pkg::CWidth,
  parameter int unsigned AddrWidth = snax_gemm_pkg::AddrWidth,
  parameter type tcdm_req_t = snax_gemm_pkg::tcdm_req_t,
  parameter type tcdm_rsp_t = snax_gemm_pkg::tcdm_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 c_valid_i,
  output logic                 c_ready_o,
  input  logic [CWidth-1:0]    c_data_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] beat_stride_i,
  output tcdm_req_t            tcdm_req_o [TcdmPorts],
  input  tcdm_rsp_t            tcdm_rsp_i [TcdmPorts],
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned Beats     = beat_count(CWidth, TcdmPorts, DataWidth);
  localparam int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned WordBytes = DataWidth / 8;

  state_e                                       state_q;
  logic [BeatW-1:0]                             beat_q;
  logic [TcdmPorts-1:0]                         sent_q;
  logic [Beats-1:0][TcdmPorts-1:0][DataWidth-1:0] c_q;
  logic [AddrWidth-1:0]                         base_q;
  logic [AddrWidth-1:0]                         stride_q;
  logic                                         busy_q;
  logic                                         done_q;

  logic                 in_write;
  logic                 c_hs;
  logic [TcdmPorts-1:0] req_valid;
  logic [TcdmPorts-1:0] hs;
  logic                 beat_done;
  logic                 last_beat;
  logic [AddrWidth-1:0] beat_addr;
  logic [TcdmPorts-1:0] unused_rsp;

  assign in_write  = (state_q == WRITE);
  assign c_ready_o = (state_q == IDLE);
  assign c_hs      = c_valid_i && c_ready_o;
  assign beat_done = in_write && (&(sent_q | hs));
  assign last_beat = (beat_q == BeatW'(Beats - 1));
  assign busy_o    = busy_q;
  assign done_o    = done_q;

  // Address arithmetic wraps at AddrWidth by construction of the operand widths.
  always_comb begin
    beat_addr  = base_q + AddrWidth'(beat_q) * stride_q;
    req_valid  = '0;
    hs         = '0;
    unused_rsp = '0;
    for (int i = 0; i < TcdmPorts; i++) begin
      req_valid[i]  = in_write && !sent_q[i];
      hs[i]         = req_valid[i] && tcdm_rsp_i[i].q_ready;
      unused_rsp[i] = ^{tcdm_rsp_i[i].p_valid, tcdm_rsp_i[i].p.data};
      tcdm_req_o[i]       = '0;
      tcdm_req_o[i].q.amo = AMONone;
      if (in_write) begin
        tcdm_req_o[i].q_valid = req_valid[i];
        tcdm_req_o[i].q.addr  = beat_addr + AddrWidth'(unsigned'(i) * WordBytes);
        tcdm_req_o[i].q.write = 1'b1;
        tcdm_req_o[i].q.data  = c_q[beat_q][i];
        tcdm_req_o[i].q.strb  = '1;
        tcdm_req_o[i].q.user  = '0;
      end
    end
  end

  // Ports already accepted stay silent until every port has finished the beat.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      sent_q   <= '0;
      c_q      <= '0;
      base_q   <= '0;
      stride_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (c_hs) begin
            state_q  <= WRITE;
            c_q      <= c_data_i;
            base_q   <= base_addr_i;
            stride_q <= beat_stride_i;
            beat_q   <= '0;
            sent_q   <= '0;
            busy_q   <= 1'b1;
          end
        end
        WRITE: begin
          if (beat_done) begin
            sent_q <= '0;
            if (last_beat) begin
              state_q <= IDLE;
              beat_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end else begin
            sent_q <= sent_q | hs;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snax_gemm_c_writer.sv
// Directed self-checking bench for snax_gemm_c_writer: basic tile, stalled port,
// back-to-back tiles, address wrap, mid-tile reset and input changes after capture.
module tb_snax_gemm_c_writer;
  import snax_gemm_pkg::*;

  logic                 clk_i;
  logic                 rst_ni;
  logic                 c_valid_i;
  logic                 c_ready_o;
  logic [CWidth-1:0]    c_data_i;
  logic [AddrWidth-1:0] base_addr_i;
  logic [AddrWidth-1:0] beat_stride_i;
  tcdm_req_t            tcdm_req_o [TcdmPorts];
  tcdm_rsp_t            tcdm_rsp_i [TcdmPorts];
  logic                 busy_o;
  logic                 done_o;

  logic [TcdmPorts-1:0] qValidVec;
  int vecCount = 0;
  int errCount = 0;

  snax_gemm_c_writer dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .c_valid_i     (c_valid_i),
    .c_ready_o     (c_ready_o),
    .c_data_i      (c_data_i),
    .base_addr_i   (base_addr_i),
    .beat_stride_i (beat_stride_i),
    .tcdm_req_o    (tcdm_req_o),
    .tcdm_rsp_i    (tcdm_rsp_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always_comb begin
    qValidVec = '0;
    for (int i = 0; i < TcdmPorts; i++) qValidVec[i] = tcdm_req_o[i].q_valid;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expected);
    vecCount++;
    assert (obs === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expected);
    end
  endtask

  task automatic setReady(input logic [TcdmPorts-1:0] mask);
    for (int i = 0; i < TcdmPorts; i++) begin
      tcdm_rsp_i[i].q_ready = mask[i];
      tcdm_rsp_i[i].p_valid = 1'b0;
      tcdm_rsp_i[i].p.data  = '0;
    end
  endtask

  // Tile word k holds seed + k, so beat b port i carries seed + 16*b + i.
  task automatic applyStimulus(input logic valid, input logic [63:0] seed,
                               input logic [AddrWidth-1:0] base, input logic [AddrWidth-1:0] stride);
    c_valid_i = valid;
    for (int k = 0; k < CWidth / DataWidth; k++) c_data_i[k*DataWidth +: DataWidth] = seed + 64'(k);
    base_addr_i   = base;
    beat_stride_i = stride;
  endtask

  task automatic scrambleInputs();
    for (int k = 0; k < CWidth / 32; k++) c_data_i[k*32 +: 32] = $urandom;
    base_addr_i   = AddrWidth'($urandom);
    beat_stride_i = AddrWidth'($urandom);
  endtask

  task automatic checkBeat(input string tag, input int beat, input logic [63:0] seed,
                           input logic [AddrWidth-1:0] base, input logic [AddrWidth-1:0] stride,
                           input logic [TcdmPorts-1:0] expValid);
    logic [AddrWidth-1:0] expAddr;
    checkOutput({tag, "_valid"}, 64'(qValidVec), 64'(expValid));
    for (int i = 0; i < TcdmPorts; i++) begin
      if (expValid[i]) begin
        expAddr = base + AddrWidth'(beat) * stride + AddrWidth'(8 * i);
        checkOutput($sformatf("%s_addr%0d", tag, i), 64'(tcdm_req_o[i].q.addr), 64'(expAddr));
        checkOutput($sformatf("%s_data%0d", tag, i), tcdm_req_o[i].q.data, seed + 64'(16 * beat + i));
      end
    end
    checkOutput({tag, "_write"}, 64'(tcdm_req_o[0].q.write), 64'h1);
    checkOutput({tag, "_strb"}, 64'(tcdm_req_o[0].q.strb), 64'hFF);
    checkOutput({tag, "_busy"}, 64'(busy_o), 64'h1);
    checkOutput({tag, "_ready"}, 64'(c_ready_o), 64'h0);
  endtask

  task automatic checkIdle(input string tag, input logic expDone);
    checkOutput({tag, "_valid"}, 64'(qValidVec), 64'h0);
    checkOutput({tag, "_done"}, 64'(done_o), 64'(expDone));
    checkOutput({tag, "_ready"}, 64'(c_ready_o), 64'h1);
    checkOutput({tag, "_busy"}, 64'(busy_o), 64'h0);
    checkOutput({tag, "_addr0"}, 64'(tcdm_req_o[0].q.addr), 64'h0);
    checkOutput({tag, "_data0"}, tcdm_req_o[0].q.data, 64'h0);
    checkOutput({tag, "_amo0"}, 64'(tcdm_req_o[0].q.amo), 64'(AMONone));
  endtask

  initial begin
    rst_ni = 1'b0;
    applyStimulus(1'b0, 64'h0, '0, '0);
    setReady('1);
    tick();
    tick();
    checkOutput("rst_busy", 64'(busy_o), 64'h0);
    checkOutput("rst_done", 64'(done_o), 64'h0);
    checkOutput("rst_valid", 64'(qValidVec), 64'h0);
    rst_ni = 1'b1;
    tick();
    checkIdle("post_rst", 1'b0);

    // Basic tile, inputs scrambled every cycle after capture.
    $display("[TB] basic tile");
    applyStimulus(1'b1, 64'h0, 17'h00100, 17'h00080);
    checkOutput("basic_hs_ready", 64'(c_ready_o), 64'h1);
    tick();
    c_valid_i = 1'b0;
    scrambleInputs();
    checkBeat("basic_b0", 0, 64'h0, 17'h00100, 17'h00080, '1);
    checkOutput("basic_b0_addr5", 64'(tcdm_req_o[5].q.addr), 64'h00128);
    tick();
    scrambleInputs();
    checkBeat("basic_b1", 1, 64'h0, 17'h00100, 17'h00080, '1);
    checkOutput("basic_b1_data3", tcdm_req_o[3].q.data, 64'd19);
    tick();
    checkIdle("basic_done", 1'b1);
    tick();
    checkIdle("basic_after", 1'b0);

    // Port 5 withholds ready for the first four cycles of beat 0.
    $display("[TB] staggered ready");
    applyStimulus(1'b1, 64'h1000, 17'h00200, 17'h00080);
    setReady(16'hFFDF);
    tick();
    c_valid_i = 1'b0;
    checkBeat("stag_b0", 0, 64'h1000, 17'h00200, 17'h00080, '1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      checkBeat($sformatf("stag_t%0d", c), 0, 64'h1000, 17'h00200, 17'h00080, 16'h0020);
    end
    tick();
    setReady('1);
    checkBeat("stag_t5", 0, 64'h1000, 17'h00200, 17'h00080, 16'h0020);
    checkOutput("stag_t5_addr5", 64'(tcdm_req_o[5].q.addr), 64'h00228);
    tick();
    checkBeat("stag_b1", 1, 64'h1000, 17'h00200, 17'h00080, '1);
    tick();
    checkIdle("stag_done", 1'b1);
    tick();

    // Two tiles back to back with c_valid_i held high.
    $display("[TB] back to back");
    applyStimulus(1'b1, 64'h2000, 17'h00400, 17'h00100);
    tick();
    applyStimulus(1'b1, 64'h5000, 17'h00800, 17'h00040);
    checkBeat("b2b_a0", 0, 64'h2000, 17'h00400, 17'h00100, '1);
    tick();
    checkBeat("b2b_a1", 1, 64'h2000, 17'h00400, 17'h00100, '1);
    tick();
    checkOutput("b2b_done_a", 64'(done_o), 64'h1);
    checkOutput("b2b_ready_a", 64'(c_ready_o), 64'h1);
    checkOutput("b2b_valid_gap", 64'(qValidVec), 64'h0);
    tick();
    c_valid_i = 1'b0;
    checkBeat("b2b_b0", 0, 64'h5000, 17'h00800, 17'h00040, '1);
    checkOutput("b2b_b0_addr1", 64'(tcdm_req_o[1].q.addr), 64'h00808);
    tick();
    checkBeat("b2b_b1", 1, 64'h5000, 17'h00800, 17'h00040, '1);
    tick();
    checkIdle("b2b_done_b", 1'b1);
    tick();

    // Address wrap past 2^17.
    $display("[TB] address wrap");
    applyStimulus(1'b1, 64'h3000, 17'h1FFC0, 17'h00040);
    tick();
    c_valid_i = 1'b0;
    checkBeat("wrap_b0", 0, 64'h3000, 17'h1FFC0, 17'h00040, '1);
    checkOutput("wrap_b0_addr7", 64'(tcdm_req_o[7].q.addr), 64'h1FFF8);
    checkOutput("wrap_b0_addr8", 64'(tcdm_req_o[8].q.addr), 64'h00000);
    tick();
    checkBeat("wrap_b1", 1, 64'h3000, 17'h1FFC0, 17'h00040, '1);
    checkOutput("wrap_b1_addr0", 64'(tcdm_req_o[0].q.addr), 64'h00000);
    checkOutput("wrap_b1_addr1", 64'(tcdm_req_o[1].q.addr), 64'h00008);
    tick();
    checkIdle("wrap_done", 1'b1);
    tick();

    // Reset in the middle of a stalled beat 0.
    $display("[TB] reset mid beat");
    applyStimulus(1'b1, 64'h4000, 17'h00300, 17'h00080);
    setReady('0);
    tick();
    c_valid_i = 1'b0;
    checkBeat("rstmid_b0", 0, 64'h4000, 17'h00300, 17'h00080, '1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    setReady('1);
    checkIdle("rstmid_r", 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkIdle($sformatf("rstmid_after%0d", c), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/snax_gemm_c_writer.md
# snax_gemm_c_writer

Output stage downstream of the SNAX GEMM core. It captures one 2048-bit C result tile through a valid/ready handshake and writes it to TCDM as multiple full-width beats across all TCDM ports. Each port has its own request handshake. It pulses `done_o` when the last word has been accepted, which frees the GEMM controller from holding write state.

## Interface
Parameters:
- `DataWidth`, 64: TCDM word width in bits.
- `TcdmPorts`, 16: number of TCDM request ports.
- `CWidth`, 2048: C tile width in bits; must be a multiple of `TcdmPorts*DataWidth`.
- `AddrWidth`, 17: TCDM byte address width.
- `tcdm_req_t`, logic: TCDM request struct (`q_valid`, `q.addr`, `q.write`, `q.amo`, `q.data`, `q.strb`, `q.user`).
- `tcdm_rsp_t`, logic: TCDM response struct (`q_ready`, `p_valid`, `p.data`).

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `c_valid_i` in 1: C tile valid.
- `c_ready_o` out 1: block can accept a tile.
- `c_data_i` in `CWidth`: C tile; word k is `[k*DataWidth +: DataWidth]`.
- `base_addr_i` in `AddrWidth`: byte address of word 0; sampled on tile handshake.
- `beat_stride_i` in `AddrWidth`: byte offset between beats; sampled on tile handshake.
- `tcdm_req_o` out `[TcdmPorts]` of `tcdm_req_t`: write requests.
- `tcdm_rsp_i` in `[TcdmPorts]` of `tcdm_rsp_t`: only `q_ready` is used.
- `busy_o` out 1: a tile is being written.
- `done_o` out 1: one-cycle pulse after the last beat completes.

## Operation
- Beats = `CWidth/(TcdmPorts*DataWidth)`, which is 2 at the defaults.
- States:
  - IDLE: `c_ready_o`=1.
  - WRITE.
- IDLE → WRITE on `c_valid_i & c_ready_o`. That cycle latches `c_data_i` into `c_q`, latches base and stride, and sets beat counter b=0 and `sent` mask=0.
- In WRITE, port i drives:
  - `q_valid` = !`sent[i]`.
  - `q.write`=1, `q.amo`=AMONone, `q.strb`=all ones, `q.user`=0.
  - `q.addr` = base + b*stride + i*(DataWidth/8), truncated to `AddrWidth` (wraps modulo 2^AddrWidth, no error).
  - `q.data` = `c_q[(b*TcdmPorts+i)*DataWidth +: DataWidth]`.
- `sent[i]` sets on `q_valid & q_ready`. Ports complete independently, in any order and in any cycle.
- A beat completes when (`sent` | this-cycle handshakes) is all ones. Then `sent` clears and b increments.
- If the completing beat is b=Beats-1, the next state is IDLE and `done_o` is registered high for exactly one cycle, the first IDLE cycle.
- A port that has already been accepted holds `q_valid`=0 until the next beat. No duplicate writes.
- `q_valid` never drops before its handshake. `addr` and `data` stay stable while `q_valid` is high.
- Responses (`p_valid`, `p.data`) are ignored; writes are posted.
- Outside WRITE, all `q_valid`=0 and all other request fields are 0 (`amo`=AMONone).
- `c_data_i`, base and stride may change freely after the handshake without affecting the tile in flight.

## Timing
- Reset (sampled `rst_ni`=0 at a clock edge) forces: state=IDLE, b=0, `sent`=0, `c_q`=0, `busy_o`=0, `done_o`=0, all `q_valid`=0. From the next cycle `c_ready_o`=1.
- Reset mid-tile abandons the remaining words. Already-accepted writes stand.
- With all `q_ready`=1, a handshake at cycle T gives:
  - beat 0 at T+1.
  - beat 1 at T+2.
  - `done_o`=1 and `c_ready_o`=1 at T+3.
- Back-to-back tiles: the next handshake can occur in the `done_o` cycle, so throughput is Beats+1 cycles per tile.
- `busy_o` = (state==WRITE), registered.
- `done_o` and `c_ready_o` may both be high in the same cycle.
- `c_valid_i` in WRITE is ignored (`c_ready_o`=0); the upstream holds the tile.
- Stalls: with port i at `q_ready`=0 for N cycles, the beat extends by N cycles and the other ports stay idle after their acceptance.

## Structure
- Shared package `snax_gemm_pkg`: state enum (`IDLE`, `WRITE`), `CWidth`, and the beat-count localparam function.
- Single module, no sub-module. The `sent` mask and beat counter are small enough to stay inline.

## Test plan
- Basic tile: `c_data_i` word k = k, base=0x100, stride=0x80, `q_ready`=1 → beat 0 writes port i addr 0x100+8i with data i; beat 1 writes 0x180+8i with data 16+i; `done_o` at T+3.
- Staggered ready: port 5 `q_ready`=0 for 4 cycles in beat 0 → ports ≠5 issue exactly once; beat 1 starts the cycle after port 5 is accepted; `done_o` at T+7.
- Back-to-back: second `c_valid_i` held high → second handshake in the `done_o` cycle; two tiles complete in 6 cycles; second tile uses its own base.
- Address wrap: base=0x1FFC0, stride=0x40 → beat 1 port 0 addr=0x00000, port 1 addr=0x00008.
- Reset mid-beat: `rst_ni`=0 for 1 cycle during beat 0 → all `q_valid`=0 next cycle, `done_o` never pulses, `c_ready_o`=1.
- Input change after capture: `c_data_i` toggled every cycle during WRITE → written data equals the captured tile.
